// File: rtl/bcd_updown_counter_mux.sv
// Multi-digit BCD up/down counter with a tick prescaler, synchronous load,
// pause and a terminal-count pulse, driving a time-multiplexed common-anode
// 7-segment display (active-low segments and anodes).
module bcd_updown_counter_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up_down,
  input  logic                  pause,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     an_out
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Active-low {a,b,c,d,e,f,g}; non-decimal codes leave the digit dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [4*DIGITS-1:0] inc_val, dec_val, load_val;
  logic [DIGITS-1:0]   is9, is0, all9_below, all0_below, zero_from;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tc_q, tc_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick, scan_last, wrap_up, wrap_dn;

  assign tick      = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign scan_last = (scan_q == SCAN_W'(SCAN_DIV - 1));
  assign wrap_up   = &is9;
  assign wrap_dn   = &is0;

  // Per-digit next values. A digit steps only when every lower digit is at
  // its rollover value (9 going up, 0 going down), so carries are computed as
  // prefix reductions instead of a serial chain.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      assign dig     = bcd_q[4*gi +: 4];
      assign is9[gi] = (dig == 4'd9);
      assign is0[gi] = (dig == 4'd0);
      if (gi == 0) begin : g_lsd
        assign all9_below[gi] = 1'b1;
        assign all0_below[gi] = 1'b1;
      end else begin : g_upper
        assign all9_below[gi] = &is9[gi-1:0];
        assign all0_below[gi] = &is0[gi-1:0];
      end
      assign zero_from[gi]       = &is0[DIGITS-1:gi];
      assign inc_val[4*gi +: 4]  = all9_below[gi] ? (is9[gi] ? 4'd0 : dig + 4'd1) : dig;
      assign dec_val[4*gi +: 4]  = all0_below[gi] ? (is0[gi] ? 4'd9 : dig - 4'd1) : dig;
      assign load_val[4*gi +: 4] = (load_bcd[4*gi +: 4] > 4'd9) ? 4'd0 : load_bcd[4*gi +: 4];
    end
  endgenerate

  // Count path: load beats pause, pause swallows the tick, otherwise step on tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    bcd_d   = bcd_q;
    tc_d    = 1'b0;
    if (load) begin
      bcd_d   = load_val;
      presc_d = '0;
    end else if (!pause && tick) begin
      if (up_down) begin
        bcd_d = inc_val;
        tc_d  = wrap_up;
      end else begin
        bcd_d = dec_val;
        tc_d  = wrap_dn;
      end
    end
  end

  // Digit scanning: hold each digit slot for SCAN_DIV cycles.
  always_comb begin
    scan_d = scan_last ? '0 : scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_last) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display decode for the digit currently selected, with optional leading-zero blanking.
  always_comb begin
    logic [3:0] nib;
    logic       blank;
    nib   = 4'd0;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib   = bcd_q[4*i +: 4];
        blank = (BLANK_LZ != 0) && (i > 0) && zero_from[i];
      end
    end
    seg_d = blank ? 7'b1111111 : seg_decode(nib);
    an_d  = ~(DIGITS'(1) << idx_q);
  end

  // State registers; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcd_q   <= '0;
      tc_q    <= 1'b0;
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b0000001;
      an_q    <= ~(DIGITS'(1));
    end else begin
      bcd_q   <= bcd_d;
      tc_q    <= tc_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bcd_out = bcd_q;
  assign tc      = tc_q;
  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_bcd_updown_counter_mux.sv
// Bench for bcd_updown_counter_mux: two instances (with and without
// leading-zero blanking) share stimulus; an integer model is compared every
// cycle, and directed steps pin literal expected values.
module tb_bcd_updown_counter_mux;
  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int MOD      = 10 ** DIGITS;

  logic clk = 1'b0;
  logic reset, up_down, pause, load;
  logic [4*DIGITS-1:0] load_bcd;
  logic [4*DIGITS-1:0] bcd0, bcd1;
  logic tc0, tc1;
  logic [6:0] seg0, seg1;
  logic [DIGITS-1:0] an0, an1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_mux #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut0 (
    .clk(clk), .reset(reset), .up_down(up_down), .pause(pause), .load(load),
    .load_bcd(load_bcd), .bcd_out(bcd0), .tc(tc0), .seg_out(seg0), .an_out(an0));

  bcd_updown_counter_mux #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut1 (
    .clk(clk), .reset(reset), .up_down(up_down), .pause(pause), .load(load),
    .load_bcd(load_bcd), .bcd_out(bcd1), .tc(tc1), .seg_out(seg1), .an_out(an1));

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp, input bit verbose);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end else if (verbose) begin
      $display("check %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int cnt, input int idx, input bit blz);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (blz && idx > 0 && cnt < p) return 7'b1111111;
    return seg_of((cnt / p) % 10);
  endfunction

  function automatic int load_value(input logic [4*DIGITS-1:0] v);
    int val = 0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int nib = int'(v[4*i +: 4]);
      val = val + ((nib > 9) ? 0 : nib) * p;
      p = p * 10;
    end
    return val;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int cnt);
    logic [4*DIGITS-1:0] r = '0;
    int p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((cnt / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  int m_cnt = 0, m_presc = 0, m_scan = 0, m_idx = 0;
  bit m_tc = 1'b0, m_valid = 1'b0;
  logic [6:0] m_seg0 = 7'b0000001, m_seg1 = 7'b0000001;
  logic [DIGITS-1:0] m_an = '1;

  always @(posedge clk) begin
    if (!reset) begin
      m_cnt <= 0; m_presc <= 0; m_scan <= 0; m_idx <= 0; m_tc <= 1'b0;
      m_seg0 <= 7'b0000001; m_seg1 <= 7'b0000001;
      m_an <= ~(DIGITS'(1)); m_valid <= 1'b1;
    end else begin
      m_seg0 <= exp_seg(m_cnt, m_idx, 1'b0);
      m_seg1 <= exp_seg(m_cnt, m_idx, 1'b1);
      m_an   <= ~(DIGITS'(1) << m_idx);
      m_scan <= (m_scan == SCAN_DIV - 1) ? 0 : m_scan + 1;
      m_idx  <= (m_scan == SCAN_DIV - 1) ? (m_idx + 1) % DIGITS : m_idx;
      m_presc <= (m_presc + 1) % TICK_DIV;
      m_tc <= 1'b0;
      if (load) begin
        m_cnt <= load_value(load_bcd);
        m_presc <= 0;
      end else if (!pause && m_presc == TICK_DIV - 1) begin
        if (up_down) begin
          m_cnt <= (m_cnt + 1) % MOD;
          m_tc  <= (m_cnt == MOD - 1);
        end else begin
          m_cnt <= (m_cnt + MOD - 1) % MOD;
          m_tc  <= (m_cnt == 0);
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_bcd0", 16'(bcd0), 16'(to_bcd(m_cnt)), 1'b0);
      chk("m_bcd1", 16'(bcd1), 16'(to_bcd(m_cnt)), 1'b0);
      chk("m_tc0",  16'(tc0),  16'(m_tc), 1'b0);
      chk("m_tc1",  16'(tc1),  16'(m_tc), 1'b0);
      chk("m_seg0", 16'(seg0), 16'(m_seg0), 1'b0);
      chk("m_seg1", 16'(seg1), 16'(m_seg1), 1'b0);
      chk("m_an0",  16'(an0),  16'(m_an), 1'b0);
      chk("m_an1",  16'(an1),  16'(m_an), 1'b0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_bcd = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit tc_seen;
    logic [DIGITS-1:0] an_hist [0:7];
    reset = 1'b0; up_down = 1'b1; pause = 1'b0; load = 1'b0; load_bcd = '0;
    wait_cyc(2);
    chk("rst_bcd", 16'(bcd0), 16'h0000, 1'b1);
    chk("rst_tc",  16'(tc0),  16'h0000, 1'b1);
    chk("rst_seg", 16'(seg0), 16'h0001, 1'b1);
    chk("rst_an",  16'(an0),  16'h0002, 1'b1);

    // 1: ten up ticks from zero
    reset = 1'b1;
    tc_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (tc0) tc_seen = 1'b1;
    end
    chk("t1_bcd", 16'(bcd0), 16'h0010, 1'b1);
    chk("t1_tc_never", 16'(tc_seen), 16'h0000, 1'b1);

    // 2: wrap up from 99
    do_load(8'h99);
    chk("t2_load", 16'(bcd0), 16'h0099, 1'b1);
    wait_cyc(3);
    chk("t2_hold", 16'(bcd0), 16'h0099, 1'b1);
    wait_cyc(1);
    chk("t2_wrap", 16'(bcd0), 16'h0000, 1'b1);
    chk("t2_tc1",  16'(tc0),  16'h0001, 1'b1);
    wait_cyc(1);
    chk("t2_tc0",  16'(tc0),  16'h0000, 1'b1);
    wait_cyc(3);
    chk("t2_next", 16'(bcd0), 16'h0001, 1'b1);
    chk("t2_tcn",  16'(tc0),  16'h0000, 1'b1);

    // 3: wrap down from 00
    up_down = 1'b0;
    do_load(8'h00);
    wait_cyc(4);
    chk("t3_wrap", 16'(bcd0), 16'h0099, 1'b1);
    chk("t3_tc1",  16'(tc0),  16'h0001, 1'b1);
    wait_cyc(1);
    chk("t3_tc0",  16'(tc0),  16'h0000, 1'b1);
    wait_cyc(3);
    chk("t3_next", 16'(bcd0), 16'h0098, 1'b1);

    // 4: pause, load while paused, invalid nibble sanitising
    pause = 1'b1;
    wait_cyc(12);
    chk("t4_pause", 16'(bcd0), 16'h0098, 1'b1);
    do_load(8'h42);
    chk("t4_load42", 16'(bcd0), 16'h0042, 1'b1);
    wait_cyc(8);
    chk("t4_hold42", 16'(bcd0), 16'h0042, 1'b1);
    do_load(8'h5A);
    chk("t4_load5a", 16'(bcd0), 16'h0050, 1'b1);
    pause = 1'b0;
    wait_cyc(4);
    chk("t4_resume", 16'(bcd0), 16'h0049, 1'b1);

    // 5: reset mid-prescale
    up_down = 1'b1;
    do_load(8'h37);
    chk("t5_load", 16'(bcd0), 16'h0037, 1'b1);
    wait_cyc(1);
    reset = 1'b0;
    #1;
    chk("t5_pre", 16'(bcd0), 16'h0037, 1'b1);
    @(negedge clk);
    chk("t5_bcd",  16'(bcd0), 16'h0000, 1'b1);
    chk("t5_tc",   16'(tc0),  16'h0000, 1'b1);
    chk("t5_seg0", 16'(seg0), 16'h0001, 1'b1);
    chk("t5_seg1", 16'(seg1), 16'h0001, 1'b1);
    chk("t5_an",   16'(an0),  16'h0002, 1'b1);
    reset = 1'b1;

    // 6: display scanning of 05, with and without blanking
    pause = 1'b1;
    do_load(8'h05);
    wait_cyc(1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      an_hist[k] = an0;
      if (an0 == 2'b10) begin
        chk("t6_d0_seg0", 16'(seg0), 16'h0024, 1'b1);
        chk("t6_d0_seg1", 16'(seg1), 16'h0024, 1'b1);
      end else if (an0 == 2'b01) begin
        chk("t6_d1_seg0", 16'(seg0), 16'h0001, 1'b1);
        chk("t6_d1_seg1", 16'(seg1), 16'h007F, 1'b1);
      end else begin
        chk("t6_an_onehot", 16'(an0), 16'h0002, 1'b1);
      end
      if (k >= 2) chk("t6_an_period", 16'(an_hist[k] ^ an_hist[k-2]), 16'h0003, 1'b1);
    end
    pause = 1'b0;
    wait_cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
